// File: rtl/audio_pkg.sv
// Shared sample types for the audio filter chain (FIR, decimator and later stages).
package audio_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned Q15_FRAC = 15;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO of sample_t: rd_data is the oldest entry whenever !empty.
module sync_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic signed [SAMPLE_W-1:0]     wr_data,
    output logic signed [SAMPLE_W-1:0]     rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    sample_t            mem_q [DEPTH];
    sample_t            mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        // A push while full is only legal when the same cycle frees a slot.
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/hb_dec2_fifo.sv
// Decimate-by-2 of the halfband FIR output into a show-ahead FIFO with sticky overflow.
module hb_dec2_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PHASE = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic signed [SAMPLE_W-1:0]     x_in,
    input  logic                           out_ready,
    input  logic                           clr_ovf,
    output logic signed [SAMPLE_W-1:0]     out_data,
    output logic                           out_valid,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           overflow
);

    localparam logic KEEP_PHASE = 1'(PHASE);

    logic phase_q, phase_d;
    logic ovf_q, ovf_d;
    logic keep, push, pop, full, empty;

    always_comb begin
        phase_d = phase_q;
        ovf_d   = ovf_q;
        keep    = in_valid && (phase_q == KEEP_PHASE);
        pop     = !empty && out_ready;
        push    = keep && (!full || pop);
        if (in_valid) begin
            phase_d = ~phase_q;
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        // A drop outranks a simultaneous clear so no loss goes unreported.
        if (keep && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (x_in),
        .rd_data (out_data),
        .full    (full),
        .empty   (empty),
        .count   (level)
    );

    assign out_valid = !empty;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_hb_dec2_fifo.sv
// Bench for hb_dec2_fifo: PHASE=0 and PHASE=1 instances share stimulus, each checked against a queue model.
module tb_hb_dec2_fifo;

    localparam int unsigned DEPTH = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [15:0] x_in;
    logic               out_ready;
    logic               clr_ovf;

    logic signed [15:0] od   [2];
    logic               ovld [2];
    logic [3:0]         lvl  [2];
    logic               ovf  [2];

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance (index == kept PHASE)
    logic signed [15:0] mq [2][$];
    logic               m_phase [2];
    logic               m_ovf   [2];

    always #5 clk = ~clk;

    hb_dec2_fifo #(.DEPTH(DEPTH), .PHASE(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in),
        .out_ready(out_ready), .clr_ovf(clr_ovf), .out_data(od[0]),
        .out_valid(ovld[0]), .level(lvl[0]), .overflow(ovf[0])
    );

    hb_dec2_fifo #(.DEPTH(DEPTH), .PHASE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in),
        .out_ready(out_ready), .clr_ovf(clr_ovf), .out_data(od[1]),
        .out_valid(ovld[1]), .level(lvl[1]), .overflow(ovf[1])
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("d%0d_valid", i), int'(ovld[i]), int'(mq[i].size() != 0));
            check_eq($sformatf("d%0d_level", i), int'(lvl[i]), mq[i].size());
            check_eq($sformatf("d%0d_overflow", i), int'(ovf[i]), int'(m_ovf[i]));
            if (mq[i].size() != 0) begin
                check_eq($sformatf("d%0d_data", i), int'(od[i]), int'(mq[i][0]));
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model by the rules, then compare after the edge.
    task automatic step(input logic rst, input logic iv, input int x,
                        input logic rdy, input logic clr);
        reset     = rst;
        in_valid  = iv;
        x_in      = 16'(x);
        out_ready = rdy;
        clr_ovf   = clr;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_phase[i] = 1'b0;
                m_ovf[i]   = 1'b0;
                mq[i].delete();
            end else begin
                bit was_full = (mq[i].size() == DEPTH);
                bit pop_now  = (mq[i].size() != 0) && rdy;
                bit keep_now = iv && (int'(m_phase[i]) == i);
                if (pop_now) void'(mq[i].pop_front());
                if (clr) m_ovf[i] = 1'b0;
                if (keep_now) begin
                    if (!was_full || pop_now) mq[i].push_back(16'(x));
                    else m_ovf[i] = 1'b1;
                end
                if (iv) m_phase[i] = ~m_phase[i];
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; x_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;

        // 1: reset then idle
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0);
        check_eq("t1_level", int'(lvl[0]), 0);

        // 2: every input valid, consumer always ready
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, k, 1, 0);
            if (k % 2 == 1) check_eq("t2_phase0_data", int'(od[0]), k);
            else            check_eq("t2_phase1_data", int'(od[1]), k);
        end

        // 3: backpressure fills, then a drop, then ordered drain
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) step(0, 1, -32768 + k, 0, 0);
        check_eq("t3_full_level", int'(lvl[0]), 8);
        check_eq("t3_no_ovf", int'(ovf[0]), 0);
        step(0, 1, -32752, 0, 0);
        step(0, 1, -32751, 0, 0);
        check_eq("t3_ovf", int'(ovf[0]), 1);
        check_eq("t3_level_after_drop", int'(lvl[0]), 8);
        for (int k = 0; k < 8; k++) begin
            check_eq("t3_drain", int'(od[0]), -32768 + 2 * k);
            step(0, 0, 0, 1, 0);
        end
        check_eq("t3_empty", int'(ovld[0]), 0);

        // 5: clear without drop, then clear coinciding with a drop
        step(0, 0, 0, 0, 1);
        check_eq("t5_cleared", int'(ovf[0]), 0);
        for (int k = 0; k < 16; k++) step(0, 1, 1000 + k, 0, 0);
        step(0, 1, 2000, 0, 1);
        check_eq("t5_drop_wins", int'(ovf[0]), 1);

        // 4: full with simultaneous pop and kept write
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) step(0, 1, 300 + k, 0, 0);
        step(0, 1, 555, 1, 0);
        check_eq("t4_level", int'(lvl[0]), 8);
        check_eq("t4_ovf", int'(ovf[0]), 0);
        for (int k = 0; k < 7; k++) step(0, 0, 0, 1, 0);
        check_eq("t4_last", int'(od[0]), 555);
        step(0, 0, 0, 1, 0);

        // 6: reset mid-operation
        for (int k = 0; k < 10; k++) step(0, 1, 40 + k, 0, 0);
        check_eq("t6_level5", int'(lvl[0]), 5);
        step(1, 0, 0, 0, 0);
        check_eq("t6_level0", int'(lvl[0]), 0);
        check_eq("t6_valid0", int'(ovld[0]), 0);
        step(0, 1, 100, 0, 0);
        check_eq("t6_data", int'(od[0]), 100);
        check_eq("t6_valid", int'(ovld[0]), 1);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
